// File: rtl/guess_sequencer_if.sv
// Signal bundle between the keypad decoder / scoring block side and the guess sequencer.
// key_valid and num_rdy are single-cycle strobes with no ready: every strobe is consumed, nothing back-pressures.
interface guess_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [1:0] a_cnt;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic       num_rdy;
    logic       game_clr;
    logic [1:0] digit_cnt;
    logic [3:0] attempts;
    logic       ans_phase;
    logic       win;
    logic       lose;
    logic       err;
    logic [2:0] state_dbg;

    modport master (
        output key_valid, key_code, a_cnt,
        input  num1, num2, num3, num_rdy, game_clr, digit_cnt, attempts,
        input  ans_phase, win, lose, err, state_dbg
    );

    modport slave (
        input  key_valid, key_code, a_cnt,
        output num1, num2, num3, num_rdy, game_clr, digit_cnt, attempts,
        output ans_phase, win, lose, err, state_dbg
    );
endinterface

// File: rtl/guess_sequencer.sv
// Bulls-and-cows game controller: builds 3-digit entries from keys, submits answer then guesses,
// and decides win/lose from the exact-match count returned RESP_LAT cycles after each guess.
module guess_sequencer #(
    parameter int MAX_TRY  = 8,
    parameter int RESP_LAT = 2
) (
    input logic              clk,
    input logic              reset,
    guess_sequencer_if.slave bus
);
    localparam int CW = $clog2(RESP_LAT + 1) + 1;
    localparam logic [3:0] KEY_BS    = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_NEW   = 4'hC;

    typedef enum logic [2:0] {ANS_ENTRY, GUESS_ENTRY, WAIT_RESP, WIN, LOSE} state_e;

    state_e          state_q, state_d;
    logic [2:0][3:0] slot_q, slot_d;
    logic [2:0][3:0] num_q, num_d;
    logic [1:0]      digit_cnt_q, digit_cnt_d;
    logic [3:0]      attempts_q, attempts_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            num_rdy_q, num_rdy_d;
    logic            err_q, err_d;
    logic            game_clr_q, game_clr_d;
    logic            win_q, win_d;
    logic            lose_q, lose_d;
    logic            ans_phase_q, ans_phase_d;
    logic            dup;

    // Only the occupied slots count; stale values left behind by backspace are ignored.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(digit_cnt_q) && slot_q[i] == bus.key_code) dup = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        num_d       = num_q;
        digit_cnt_d = digit_cnt_q;
        attempts_d  = attempts_q;
        wait_d      = wait_q;
        win_d       = win_q;
        lose_d      = lose_q;
        num_rdy_d   = 1'b0;
        err_d       = 1'b0;
        game_clr_d  = 1'b0;

        if (bus.key_valid && bus.key_code == KEY_NEW) begin
            state_d     = ANS_ENTRY;
            slot_d      = '0;
            num_d       = '0;
            digit_cnt_d = 2'd0;
            attempts_d  = 4'd0;
            win_d       = 1'b0;
            lose_d      = 1'b0;
            game_clr_d  = 1'b1;
        end else begin
            case (state_q)
                ANS_ENTRY, GUESS_ENTRY: begin
                    if (bus.key_valid) begin
                        if (bus.key_code <= 4'd9) begin
                            if (digit_cnt_q != 2'd3 && !dup) begin
                                case (digit_cnt_q)
                                    2'd0:    slot_d[0] = bus.key_code;
                                    2'd1:    slot_d[1] = bus.key_code;
                                    default: slot_d[2] = bus.key_code;
                                endcase
                                digit_cnt_d = digit_cnt_q + 2'd1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (bus.key_code == KEY_BS) begin
                            if (digit_cnt_q != 2'd0) digit_cnt_d = digit_cnt_q - 2'd1;
                            else                     err_d = 1'b1;
                        end else if (bus.key_code == KEY_ENTER) begin
                            if (digit_cnt_q == 2'd3) begin
                                num_d       = slot_q;
                                num_rdy_d   = 1'b1;
                                digit_cnt_d = 2'd0;
                                if (state_q == ANS_ENTRY) begin
                                    state_d = GUESS_ENTRY;
                                end else begin
                                    attempts_d = attempts_q + 4'd1;
                                    wait_d     = '0;
                                    state_d    = WAIT_RESP;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                WAIT_RESP: begin
                    // wait_q is 0 in the num_rdy cycle, so a_cnt is taken RESP_LAT cycles later.
                    wait_d = wait_q + 1'b1;
                    if (wait_q == CW'(RESP_LAT)) begin
                        if (bus.a_cnt == 2'd3) begin
                            state_d = WIN;
                            win_d   = 1'b1;
                        end else if (attempts_q == 4'(MAX_TRY)) begin
                            state_d = LOSE;
                            lose_d  = 1'b1;
                        end else begin
                            state_d = GUESS_ENTRY;
                        end
                    end
                end
                default: ;
            endcase
        end

        ans_phase_d = (state_d == ANS_ENTRY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ANS_ENTRY;
            slot_q      <= '0;
            num_q       <= '0;
            digit_cnt_q <= 2'd0;
            attempts_q  <= 4'd0;
            wait_q      <= '0;
            num_rdy_q   <= 1'b0;
            err_q       <= 1'b0;
            game_clr_q  <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            ans_phase_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            num_q       <= num_d;
            digit_cnt_q <= digit_cnt_d;
            attempts_q  <= attempts_d;
            wait_q      <= wait_d;
            num_rdy_q   <= num_rdy_d;
            err_q       <= err_d;
            game_clr_q  <= game_clr_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            ans_phase_q <= ans_phase_d;
        end
    end

    assign bus.num1      = num_q[0];
    assign bus.num2      = num_q[1];
    assign bus.num3      = num_q[2];
    assign bus.num_rdy   = num_rdy_q;
    assign bus.game_clr  = game_clr_q;
    assign bus.digit_cnt = digit_cnt_q;
    assign bus.attempts  = attempts_q;
    assign bus.ans_phase = ans_phase_q;
    assign bus.win       = win_q;
    assign bus.lose      = lose_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_guess_sequencer.sv
// Bench for guess_sequencer: directed game scenarios plus random keystrokes, all checked
// cycle by cycle against a queue-based model of the game rules.
module tb_guess_sequencer;
  localparam int MAX_TRY  = 8;
  localparam int RESP_LAT = 2;

  logic clk;
  logic reset;
  guess_sequencer_if bus ();

  guess_sequencer #(.MAX_TRY(MAX_TRY), .RESP_LAT(RESP_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_buf[$];
  bit          m_ans_set;
  int          m_wait;
  bit          m_win;
  bit          m_lose;
  int          m_attempts;
  logic [11:0] m_nums;
  bit          e_rdy;
  bit          e_err;
  bit          e_clr;
  logic [11:0] exp_q[$];
  logic [1:0]  ac_drv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_buf.delete();
    m_ans_set  = 1'b0;
    m_wait     = -1;
    m_win      = 1'b0;
    m_lose     = 1'b0;
    m_attempts = 0;
    m_nums     = '0;
  endtask

  task automatic model_edge(input bit r, input bit kv, input logic [3:0] kc, input logic [1:0] ac);
    bit found;
    e_rdy = 1'b0;
    e_err = 1'b0;
    e_clr = 1'b0;
    if (r) begin
      model_clear();
    end else if (kv && kc == 4'hC) begin
      model_clear();
      e_clr = 1'b1;
    end else if (m_wait >= 0) begin
      if (m_wait == 0) begin
        m_wait = -1;
        if (ac == 2'd3) m_win = 1'b1;
        else if (m_attempts == MAX_TRY) m_lose = 1'b1;
      end else begin
        m_wait--;
      end
    end else if (kv && !m_win && !m_lose) begin
      if (kc <= 4'd9) begin
        found = 1'b0;
        foreach (m_buf[i]) if (m_buf[i] == int'(kc)) found = 1'b1;
        if (m_buf.size() < 3 && !found) m_buf.push_back(int'(kc));
        else e_err = 1'b1;
      end else if (kc == 4'hA) begin
        if (m_buf.size() > 0) void'(m_buf.pop_back());
        else e_err = 1'b1;
      end else if (kc == 4'hB) begin
        if (m_buf.size() == 3) begin
          m_nums = {4'(m_buf[0]), 4'(m_buf[1]), 4'(m_buf[2])};
          e_rdy  = 1'b1;
          exp_q.push_back(m_nums);
          m_buf.delete();
          if (!m_ans_set) begin
            m_ans_set = 1'b1;
          end else begin
            m_attempts++;
            m_wait = RESP_LAT;
          end
        end else begin
          e_err = 1'b1;
        end
      end else begin
        e_err = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("num_rdy", bus.num_rdy, e_rdy);
    chk("err", bus.err, e_err);
    chk("game_clr", bus.game_clr, e_clr);
    chk("digit_cnt", bus.digit_cnt, m_buf.size());
    chk("attempts", bus.attempts, m_attempts);
    chk("ans_phase", bus.ans_phase, !m_ans_set);
    chk("win", bus.win, m_win);
    chk("lose", bus.lose, m_lose);
    chk("nums", {bus.num1, bus.num2, bus.num3}, m_nums);
    if (bus.num_rdy) begin
      if (exp_q.size() == 0) chk("sb_extra_rdy", 1, 0);
      else chk("sb_nums", {bus.num1, bus.num2, bus.num3}, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic step(input bit r, input bit kv, input logic [3:0] kc, input logic [1:0] ac);
    @(negedge clk);
    reset         = r;
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.a_cnt     = ac;
    model_edge(r, kv, kc, ac);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b0, 1'b1, k, ac_drv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, ac_drv);
  endtask

  task automatic enter3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    key(a);
    key(b);
    key(c);
    key(4'hB);
  endtask

  initial begin
    bit         r;
    bit         kv;
    logic [3:0] kc;
    logic [1:0] ac;
    int         sel;

    reset = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.a_cnt     = 2'd0;
    ac_drv = 2'd0;
    model_clear();
    step(1'b1, 1'b0, 4'h0, 2'd0);
    step(1'b1, 1'b0, 4'h0, 2'd0);
    chk("rst_ans_phase", bus.ans_phase, 1);

    // answer entry
    enter3(4'd1, 4'd2, 4'd3);
    chk("ans_nums", {bus.num1, bus.num2, bus.num3}, 12'h123);
    idle(1);
    chk("ans_phase_fell", bus.ans_phase, 0);

    // rejected keys during guess entry
    key(4'd4);
    key(4'd4);
    chk("dup_err", bus.err, 1);
    key(4'hA);
    key(4'hA);
    chk("bs_empty_err", bus.err, 1);
    key(4'd5);
    key(4'd6);
    key(4'hB);
    chk("short_enter_err", bus.err, 1);
    key(4'hE);
    key(4'd7);
    key(4'hB);
    idle(RESP_LAT + 1);

    // win on first guess, keys ignored afterwards
    key(4'hC);
    enter3(4'd1, 4'd2, 4'd3);
    ac_drv = 2'd3;
    enter3(4'd1, 4'd2, 4'd3);
    idle(RESP_LAT + 1);
    chk("win_first", bus.win, 1);
    chk("win_attempts", bus.attempts, 1);
    key(4'd5);
    key(4'd6);
    key(4'hB);
    key(4'hF);

    // lose after MAX_TRY misses
    ac_drv = 2'd0;
    key(4'hC);
    enter3(4'd1, 4'd2, 4'd3);
    for (int g = 0; g < MAX_TRY; g++) begin
      enter3(4'd4, 4'd5, 4'd6);
      idle(RESP_LAT + 1);
    end
    chk("lose_set", bus.lose, 1);
    chk("lose_attempts", bus.attempts, MAX_TRY);

    // win on the final attempt beats lose
    key(4'hC);
    enter3(4'd1, 4'd2, 4'd3);
    for (int g = 0; g < MAX_TRY; g++) begin
      ac_drv = (g == MAX_TRY - 1) ? 2'd3 : 2'd0;
      enter3(4'd4, 4'd5, 4'd6);
      idle(RESP_LAT + 1);
    end
    chk("last_win", bus.win, 1);
    chk("last_not_lose", bus.lose, 0);

    // new game while waiting for the response
    ac_drv = 2'd3;
    key(4'hC);
    enter3(4'd1, 4'd2, 4'd3);
    enter3(4'd4, 4'd5, 4'd6);
    key(4'hC);
    idle(RESP_LAT + 2);
    chk("nw_win", bus.win, 0);
    chk("nw_ans_phase", bus.ans_phase, 1);
    chk("nw_nums", {bus.num1, bus.num2, bus.num3}, 0);

    // reset colliding with a full-buffer enter
    ac_drv = 2'd0;
    enter3(4'd1, 4'd2, 4'd3);
    key(4'd4);
    key(4'd5);
    key(4'd6);
    step(1'b1, 1'b1, 4'hB, 2'd0);
    chk("rst_enter_rdy", bus.num_rdy, 0);
    chk("rst_enter_cnt", bus.digit_cnt, 0);
    idle(2);

    // random keystrokes, random a_cnt every cycle, occasional reset
    for (int c = 0; c < 4000; c++) begin
      r   = ($urandom_range(0, 599) == 0);
      kv  = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 99);
      if (sel < 60)      kc = 4'($urandom_range(0, 9));
      else if (sel < 80) kc = 4'hB;
      else if (sel < 92) kc = 4'hA;
      else if (sel < 93) kc = 4'hC;
      else               kc = 4'($urandom_range(13, 15));
      ac = 2'($urandom_range(0, 3));
      step(r, kv, kc, ac);
    end

    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/guess_sequencer.md
# guess_sequencer

Keypad-driven game controller for the three-digit bulls-and-cows (xA yB) game. It assembles digit keystrokes into a three-digit entry, rejecting duplicates and malformed entries. It issues the answer and then each guess to the scoring/display block as a one-cycle ready pulse, and counts attempts. It reads back the exact-match count to decide win or loss. It sits between the keypad decoder and the scoring/text-overlay block and drives that block's number and ready inputs.

## Interface
- MAX_TRY, 8: guesses allowed per game; legal range 1..15.
- RESP_LAT, 2: cycles from `num_rdy` to the cycle in which `a_cnt` is sampled; minimum 1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; `key_code` is valid this cycle.
- key_code  in  4  0x0-0x9 digit; 0xA backspace; 0xB enter; 0xC new game; 0xD-0xF illegal.
- a_cnt  in  2  exact-match count returned by the scoring block.
- num1, num2, num3  out  4 each  submitted digits, first-typed digit in `num1`; held between submissions.
- num_rdy  out  1  one-cycle pulse; `num1..3` are valid in the same cycle.
- game_clr  out  1  one-cycle pulse on new game; downstream ORs it into its reset.
- digit_cnt  out  2  digits currently in the entry buffer (0..3), for echo.
- attempts  out  4  guesses submitted this game.
- ans_phase  out  1  high while the answer is being entered.
- win, lose  out  1 each  level outputs; held until new game or reset.
- err  out  1  one-cycle pulse on a rejected key.

## Operation
- States: ANS_ENTRY, GUESS_ENTRY, WAIT_RESP, WIN, LOSE.
- Reset: state ANS_ENTRY, buffer empty. All outputs are 0; `ans_phase` is 1.
- Entry buffer holds three 4-bit slots plus `digit_cnt`. Key handling in ANS_ENTRY and GUESS_ENTRY:
  - Digit: if `digit_cnt`<3 and the digit is not already in the buffer, write it to slot `digit_cnt` and increment `digit_cnt`. Otherwise pulse `err` and leave the buffer unchanged.
  - Backspace: if `digit_cnt`>0, decrement it. Otherwise pulse `err`.
  - Enter: if `digit_cnt`==3, copy the slots to `num1..3`, pulse `num_rdy`, and clear `digit_cnt`. Otherwise pulse `err`.
  - 0xD-0xF: pulse `err`.
- ANS_ENTRY: a valid enter submits the answer and moves to GUESS_ENTRY. `attempts` is unchanged.
- GUESS_ENTRY: a valid enter submits a guess, increments `attempts`, and moves to WAIT_RESP.
- WAIT_RESP: count RESP_LAT cycles from the `num_rdy` cycle, then sample `a_cnt`:
  - `a_cnt`==3: go to WIN (takes priority on the final attempt).
  - else if `attempts`==MAX_TRY: go to LOSE.
  - else: go to GUESS_ENTRY.
- In WAIT_RESP, WIN and LOSE, all keys except 0xC are ignored with no `err`.
- New game (0xC), accepted in any state: pulse `game_clr`, go to ANS_ENTRY, and clear the buffer, `attempts`, `win`, `lose` and `num1..3`.
- Priority: reset, then new-game key, then all other keys.

## Timing
- All outputs are registered.
- `num_rdy`, `err` and `game_clr` assert in the cycle after the qualifying `key_valid` and last exactly one cycle.
- `num1..3` update in the same edge as `num_rdy`. `attempts` and `digit_cnt` also update in the edge after the key.
- With `num_rdy` in cycle T, `a_cnt` is sampled in cycle T+RESP_LAT.
  - The new state, `win` or `lose`, is visible in cycle T+RESP_LAT+1.
  - Keys are accepted again from that cycle on.
- Back-to-back `key_valid` strobes on consecutive cycles are each processed.
- Reset asserted mid-WAIT_RESP aborts the wait; nothing is sampled.
- The `attempts` counter never exceeds MAX_TRY.

## Test plan
- Reset, keys 1,2,3,enter -> `num_rdy` pulse with `num1..3`=1,2,3; `ans_phase` falls; `attempts`=0.
- Guess entry: keys 4,4 -> second 4 pulses `err`, `digit_cnt`=1. Then backspace, backspace -> second backspace pulses `err`. Then enter with 2 digits -> `err`, no `num_rdy`.
- Answer 123, guess 1,2,3,enter with `a_cnt` driven 3 at T+2 -> `win`=1 in T+3, `attempts`=1. Further digit keys produce no `err` and no `num_rdy`.
- Answer 123, with MAX_TRY=8, submit 8 guesses of 456 while `a_cnt`=0 -> `lose`=1 after the 8th response, `attempts`=8. The same sequence with `a_cnt`=3 on the 8th response -> `win`, not `lose`.
- In WAIT_RESP, key 0xC -> `game_clr` pulse, `ans_phase`=1, `attempts`=0, `num1..3`=0, no transition to WIN.
- Reset on the same cycle as a `key_valid` enter with a full buffer -> no `num_rdy`; all outputs return to their reset values.
